// File: rtl/sccb_init_seq.sv
// sccb_init_seq: boot-time camera register-table sequencer issuing SCCB writes with NACK retry.
// Define SCCB_INIT_READBACK_EN to verify every write with a read of the same sub-address.
module sccb_init_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         TBL_ADDR_W = 8,
  parameter int         DLY_UNIT   = 1000,
  parameter int         MAX_RETRY  = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [TBL_ADDR_W-1:0] tbl_addr_o,
  input  logic [17:0]           tbl_data_i,
  output logic                  sccb_req_vld_o,
  input  logic                  sccb_req_rdy_i,
  output logic                  sccb_req_rw_o,
  output logic [7:0]            sccb_req_dev_o,
  output logic [7:0]            sccb_req_sub_o,
  output logic [7:0]            sccb_req_dat_o,
  input  logic                  sccb_rsp_vld_i,
  input  logic                  sccb_rsp_err_i,
  input  logic [7:0]            sccb_rsp_dat_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [TBL_ADDR_W-1:0] err_idx_o
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, NEXT, DLY, DONE
`ifdef SCCB_INIT_READBACK_EN
    , RB_ISSUE, RB_WAIT
`endif
  } state_t;
  state_t state, state_nxt;
  logic [TBL_ADDR_W-1:0] idx;
  logic [RW-1:0] retry_cnt;
  logic abort_pend, abort_now, retry_ok, retry_inc, err_set;
  logic [1:0] code_nxt, cmd;
  logic [7:0] sub, dat;
  logic [31:0] dly_cnt, dly_load;
  assign cmd       = tbl_data_i[17:16];
  assign abort_now = abort_pend | abort_i;
  assign retry_ok  = retry_cnt < RW'(MAX_RETRY);
  assign dly_load  = tbl_data_i[7:0] == 8'd0 ? 32'd0 : 32'(tbl_data_i[7:0]) * 32'(DLY_UNIT) - 32'd1;
  assign busy_o    = state != IDLE;
  assign done_o    = state == DONE;
  assign tbl_addr_o     = idx;
  assign sccb_req_sub_o = sub;
  assign sccb_req_dat_o = dat;
  assign sccb_req_dev_o = sccb_req_vld_o ? DEV_ADDR : 8'h00;
`ifdef SCCB_INIT_READBACK_EN
  assign sccb_req_vld_o = state == ISSUE || state == RB_ISSUE;
  assign sccb_req_rw_o  = state == RB_ISSUE;
  assign retry_inc = sccb_rsp_vld_i && sccb_rsp_err_i && retry_ok && (state == WAIT_RSP || state == RB_WAIT);
`else
  assign sccb_req_vld_o = state == ISSUE;
  assign sccb_req_rw_o  = 1'b0;
  assign retry_inc = sccb_rsp_vld_i && sccb_rsp_err_i && retry_ok && state == WAIT_RSP;
  logic unused_rsp_dat;
  assign unused_rsp_dat = ^sccb_rsp_dat_i;
`endif
  always_ff @(posedge sys_clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    code_nxt  = 2'b00;
    case (state)
      IDLE:     state_nxt = start_i ? FETCH : IDLE;
      FETCH:    state_nxt = abort_now ? DONE : DECODE;
      DECODE: begin
        state_nxt = cmd == 2'b00 ? ISSUE : cmd == 2'b01 ? DLY : DONE;
        err_set   = cmd == 2'b10;
        code_nxt  = 2'b11;
      end
      ISSUE:    state_nxt = sccb_req_rdy_i ? WAIT_RSP : ISSUE;
      WAIT_RSP: if (sccb_rsp_vld_i) begin
`ifdef SCCB_INIT_READBACK_EN
        state_nxt = !sccb_rsp_err_i ? RB_ISSUE : retry_ok ? ISSUE : DONE;
`else
        state_nxt = !sccb_rsp_err_i ? NEXT : retry_ok ? ISSUE : DONE;
`endif
        err_set   = sccb_rsp_err_i && !retry_ok;
        code_nxt  = 2'b01;
      end
`ifdef SCCB_INIT_READBACK_EN
      RB_ISSUE: state_nxt = sccb_req_rdy_i ? RB_WAIT : RB_ISSUE;
      RB_WAIT:  if (sccb_rsp_vld_i) begin
        state_nxt = sccb_rsp_err_i ? (retry_ok ? RB_ISSUE : DONE) : sccb_rsp_dat_i != dat ? DONE : NEXT;
        err_set   = sccb_rsp_err_i ? !retry_ok : sccb_rsp_dat_i != dat;
        code_nxt  = sccb_rsp_err_i ? 2'b01 : 2'b10;
      end
`endif
      NEXT:     state_nxt = &idx ? DONE : FETCH;
      DLY:      state_nxt = abort_now ? DONE : dly_cnt == 32'd0 ? NEXT : DLY;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      idx        <= '0;
      retry_cnt  <= '0;
      abort_pend <= 1'b0;
      sub        <= 8'h00;
      dat        <= 8'h00;
      dly_cnt    <= 32'd0;
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
      err_idx_o  <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        idx        <= '0;
        retry_cnt  <= '0;
        err_o      <= 1'b0;
        err_code_o <= 2'b00;
        err_idx_o  <= '0;
      end
      if (state == DECODE) begin
        sub     <= tbl_data_i[15:8];
        dat     <= tbl_data_i[7:0];
        dly_cnt <= dly_load;
      end
      if (state == DLY && dly_cnt != 32'd0) dly_cnt <= dly_cnt - 32'd1;
      if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
      if (state == NEXT) begin
        retry_cnt <= '0;
        if (!(&idx)) idx <= idx + 1'b1;
      end
      if (err_set) begin
        err_o      <= 1'b1;
        err_code_o <= code_nxt;
        err_idx_o  <= idx;
      end
      abort_pend <= (state == IDLE || state == DONE) ? 1'b0 : abort_pend | abort_i;
    end
endmodule
